// File: rtl/gamma_lut_stream.sv
// Per-channel gamma lookup stage with double-buffered, host-loadable LUTs and a 2-cycle valid/ready pipe.
// Optional GAMMA_IDENTITY_INIT_EN: after reset, an init sweep fills every LUT with the identity curve.
module gamma_lut_stream #(
    parameter int DATA_W = 8,
    parameter int CH     = 3,
    parameter int CH_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic [CH*DATA_W-1:0] out_data,
    input  logic                 bypass,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [DATA_W-1:0]    cfg_addr,
    input  logic [DATA_W-1:0]    cfg_wdata,
    input  logic                 cfg_swap_req,
    output logic                 swap_pending,
    output logic                 active_bank,
    output logic                 init_busy
);

    localparam int DEPTH = 1 << DATA_W;
    localparam int PIX_W = CH * DATA_W;

    // Handshake: a beat moves on a rising edge where valid && ready; the whole
    // pipe advances together when the output register is empty or being taken.
    logic             w_adv;
    logic             w_fire;
    logic             w_sof_fire;
    logic             w_swap_now;
    logic             w_bank_sel;
    logic             w_bypass_sel;
    logic             w_cfg_en;
    logic             w_run;
    logic [PIX_W-1:0] w_map;

    logic             r_swap_pending;
    logic             r_active_bank;
    logic             r_bypass_q;

    logic             r_s1_valid;
    logic             r_s1_sof;
    logic             r_s1_bank;
    logic             r_s1_bypass;
    logic [PIX_W-1:0] r_s1_pix;

    logic             r_out_valid;
    logic             r_out_sof;
    logic [PIX_W-1:0] r_out_data;

`ifdef GAMMA_IDENTITY_INIT_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_init_addr;
    logic              w_init_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_init_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_INIT;
                    r_init_addr <= '0;
                end
                ST_INIT: begin
                    r_init_addr <= r_init_addr + 1'b1;
                    if (&r_init_addr) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The single IDLE cycle also blocks traffic so no beat can see an unfilled LUT.
    assign init_busy = (r_state == ST_INIT);
    assign w_init_we = init_busy;
    assign w_run     = (r_state == ST_RUN);
`else
    assign init_busy = 1'b0;
    assign w_run     = 1'b1;
`endif

    assign w_adv        = !r_out_valid || out_ready;
    assign in_ready     = w_adv && w_run;
    assign w_fire       = in_valid && in_ready;
    assign w_sof_fire   = w_fire && in_sof;
    assign w_swap_now   = w_sof_fire && r_swap_pending;
    assign w_bank_sel   = w_swap_now ? ~r_active_bank : r_active_bank;
    assign w_bypass_sel = w_sof_fire ? bypass : r_bypass_q;
    assign w_cfg_en     = cfg_we && w_run;

    // A new request wins over consumption so a req landing on the swapping sof stays armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_swap_pending <= 1'b0;
            r_active_bank  <= 1'b0;
            r_bypass_q     <= 1'b0;
        end else begin
            if (cfg_swap_req) begin
                r_swap_pending <= 1'b1;
            end else if (w_swap_now) begin
                r_swap_pending <= 1'b0;
            end
            if (w_swap_now) begin
                r_active_bank <= ~r_active_bank;
            end
            if (w_sof_fire) begin
                r_bypass_q <= bypass;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_sof    <= 1'b0;
            r_s1_bank   <= 1'b0;
            r_s1_bypass <= 1'b0;
            r_s1_pix    <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_fire;
            if (w_fire) begin
                r_s1_sof    <= in_sof;
                r_s1_bank   <= w_bank_sel;
                r_s1_bypass <= w_bypass_sel;
                r_s1_pix    <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_data  <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            r_out_sof   <= r_s1_valid && r_s1_sof;
            if (r_s1_valid) begin
                r_out_data <= w_map;
            end
        end
    end

    // Each channel owns two banks; cfg only ever writes the bank not in use for lookup.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        localparam logic [CH_W-1:0] LC = CH_W'(c);

        logic [DATA_W-1:0] r_bank0 [DEPTH];
        logic [DATA_W-1:0] r_bank1 [DEPTH];
        logic [DATA_W-1:0] w_pix;
        logic [DATA_W-1:0] w_rd;
        logic              w_wr_sel;

        assign w_pix    = r_s1_pix[c*DATA_W +: DATA_W];
        assign w_wr_sel = w_cfg_en && (cfg_ch == LC);

        always_ff @(posedge clk) begin
`ifdef GAMMA_IDENTITY_INIT_EN
            if (w_init_we) begin
                r_bank0[r_init_addr] <= r_init_addr;
                r_bank1[r_init_addr] <= r_init_addr;
            end else if (w_wr_sel) begin
`else
            if (w_wr_sel) begin
`endif
                if (r_active_bank) begin
                    r_bank0[cfg_addr] <= cfg_wdata;
                end else begin
                    r_bank1[cfg_addr] <= cfg_wdata;
                end
            end
        end

        assign w_rd = r_s1_bank ? r_bank1[w_pix] : r_bank0[w_pix];
        assign w_map[c*DATA_W +: DATA_W] = r_s1_bypass ? w_pix : w_rd;
    end

    assign out_valid    = r_out_valid;
    assign out_sof      = r_out_sof;
    assign out_data     = r_out_data;
    assign swap_pending = r_swap_pending;
    assign active_bank  = r_active_bank;

endmodule

// File: tb/tb_gamma_lut_stream.sv
// Self-checking bench for gamma_lut_stream: reference LUT model plus an expected-beat queue.
module tb_gamma_lut_stream;

    localparam int DW  = 8;
    localparam int NCH = 3;
    localparam int CW  = 2;
    localparam int PW  = NCH * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sof = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_sof;
    logic [PW-1:0] out_data;
    logic          bypass = 1'b0;
    logic          cfg_we = 1'b0;
    logic [CW-1:0] cfg_ch = '0;
    logic [DW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_wdata = '0;
    logic          cfg_swap_req = 1'b0;
    logic          swap_pending;
    logic          active_bank;
    logic          init_busy;

    always #5 clk = ~clk;

    gamma_lut_stream #(.DATA_W(DW), .CH(NCH), .CH_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_data(out_data),
        .bypass(bypass), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_swap_req(cfg_swap_req),
        .swap_pending(swap_pending), .active_bank(active_bank), .init_busy(init_busy)
    );

    logic [PW:0]   exp_q[$];
    logic [DW-1:0] m_lut [2][NCH][256];
    logic          m_bank = 1'b0;
    logic          m_pend = 1'b0;
    logic          m_bq = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {b, g, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: evaluated at the falling edge for the rising edge that follows.
    always @(negedge clk) begin : mon
        logic [PW:0]   e;
        logic [DW-1:0] pix;
        if (!rst_n) begin
            exp_q.delete();
            m_bank = 1'b0;
            m_pend = 1'b0;
            m_bq   = 1'b0;
`ifdef GAMMA_IDENTITY_INIT_EN
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < NCH; c++)
                    for (int a = 0; a < 256; a++)
                        m_lut[b][c][a] = 8'(a);
`endif
        end else begin
            check("active_bank", active_bank, m_bank);
            check("swap_pending", swap_pending, m_pend);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_extra", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat", {out_sof, out_data}, e);
                end
            end
            if (cfg_we && !init_busy && cfg_ch < 2'd3)
                m_lut[~m_bank][cfg_ch][cfg_addr] = cfg_wdata;
            if (in_valid && in_ready) begin
                if (in_sof) begin
                    m_bq = bypass;
                    if (m_pend) begin
                        m_bank = ~m_bank;
                        m_pend = 1'b0;
                    end
                end
                e[PW] = in_sof;
                for (int c = 0; c < NCH; c++) begin
                    pix = in_data[c*DW +: DW];
                    e[c*DW +: DW] = m_bq ? pix : m_lut[m_bank][c][pix];
                end
                exp_q.push_back(e);
            end
            if (cfg_swap_req) m_pend = 1'b1;
        end
    end

    task automatic drive_beat(input logic [PW-1:0] pix, input logic sof, input logic byp, input bit rnd);
        bit acc = 0;
        int guard = 0;
        in_valid = 1'b1;
        in_data  = pix;
        in_sof   = sof;
        bypass   = byp;
        while (!acc && guard < 200) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready;
            tick();
            cfg_we       = 1'b0;
            cfg_swap_req = 1'b0;
            guard++;
        end
        if (!acc) check("accept_timeout", acc, 1'b1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic load_bank(input int kind);
        logic [7:0] av;
        for (int c = 0; c < NCH; c++) begin
            for (int a = 0; a < 256; a++) begin
                av        = 8'(a);
                cfg_we    = 1'b1;
                cfg_ch    = 2'(c);
                cfg_addr  = av;
                cfg_wdata = (kind == 0) ? ~av : (av ^ 8'(8'h11 * (c + 1)));
                tick();
            end
        end
        cfg_we = 1'b0;
    endtask

    // Called right after a lone beat is accepted into an empty pipe.
    task automatic lat2(input logic [PW-1:0] d, input bit chk_d);
        @(negedge clk);
        check("lat_n1_valid", out_valid, 1'b0);
        @(negedge clk);
        check("lat_n2_valid", out_valid, 1'b1);
        if (chk_d) check("lat_n2_data", out_data, d);
        tick();
    endtask

`ifdef GAMMA_IDENTITY_INIT_EN
    task automatic wait_init();
        int cnt = 0;
        int guard = 0;
        @(negedge clk);
        while (!init_busy && guard < 10) begin
            guard++;
            @(negedge clk);
        end
        while (init_busy && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("init_cycles", cnt, 256);
        tick();
    endtask
`endif

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sof", out_sof, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_swap_pending", swap_pending, 1'b0);
        check("rst_active_bank", active_bank, 1'b0);
`ifdef GAMMA_IDENTITY_INIT_EN
        check("rst_in_ready", in_ready, 1'b0);
        tick();
        wait_init();
        drive_beat(px(8'd1, 8'd128, 8'd255), 1'b1, 1'b0, 0);
        lat2(px(8'd1, 8'd128, 8'd255), 1);
`else
        check("rst_init_busy", init_busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        tick();
`endif

        // Inverse curve into the shadow bank, swap at the sof
        load_bank(0);
        cfg_swap_req = 1'b1;
        tick();
        cfg_swap_req = 1'b0;
        check("swap_armed", swap_pending, 1'b1);
        drive_beat(px(8'd10, 8'd20, 8'd30), 1'b1, 1'b0, 0);
        lat2(px(8'd245, 8'd235, 8'd225), 1);
        check("t1_active_bank", active_bank, 1'b1);
        check("t1_swap_cleared", swap_pending, 1'b0);
        load_bank(1);

        // Backpressure: two beats fill the pipe, the third waits
        out_ready = 1'b0;
        drive_beat(px(8'd1, 8'd2, 8'd3), 1'b0, 1'b0, 0);
        drive_beat(px(8'd4, 8'd5, 8'd6), 1'b0, 1'b0, 0);
        in_valid = 1'b1;
        in_data  = px(8'd7, 8'd8, 8'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_hold", out_data, exp_q[0][PW-1:0]);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        begin
            bit acc = 0;
            int guard = 0;
            while (!acc && guard < 50) begin
                @(negedge clk);
                acc = in_ready;
                tick();
                guard++;
            end
            check("stall_release_accept", acc, 1'b1);
        end
        in_valid = 1'b0;
        repeat (3) tick();

        // Bypass changes only take hold at a sof
        drive_beat(px(8'h40, 8'h40, 8'h40), 1'b1, 1'b0, 0);
        drive_beat(px(8'h40, 8'h40, 8'h40), 1'b0, 1'b1, 0);
        drive_beat(px(8'h40, 8'h40, 8'h40), 1'b1, 1'b1, 0);
        drive_beat(px(8'h40, 8'h40, 8'h40), 1'b0, 1'b0, 0);
        drive_beat(px(8'h41, 8'h42, 8'h43), 1'b1, 1'b0, 0);

        // Shadow writes to entry 100 do not disturb the active curve
        for (int i = 0; i < 6; i++) begin
            cfg_we    = 1'b1;
            cfg_ch    = 2'(i % 3);
            cfg_addr  = 8'd100;
            cfg_wdata = 8'(8'h30 + i % 3);
            drive_beat(px(8'd100, 8'd100, 8'd100), 1'b0, 1'b0, 0);
        end
        cfg_swap_req = 1'b1;
        tick();
        cfg_swap_req = 1'b0;
        drive_beat(px(8'd100, 8'd100, 8'd100), 1'b1, 1'b0, 0);

        // A request arriving with the consuming sof stays armed
        cfg_swap_req = 1'b1;
        tick();
        cfg_swap_req = 1'b1;
        drive_beat(px(8'd50, 8'd60, 8'd70), 1'b1, 1'b0, 0);
        check("req_on_sof_pending", swap_pending, 1'b1);

        // Write coinciding with the swapping sof lands in the bank that goes active
        cfg_we    = 1'b1;
        cfg_ch    = 2'd0;
        cfg_addr  = 8'd5;
        cfg_wdata = 8'h77;
        drive_beat(px(8'd20, 8'd20, 8'd20), 1'b1, 1'b0, 0);
        repeat (3) tick();
        drive_beat(px(8'd5, 8'd5, 8'd5), 1'b0, 1'b0, 0);
        lat2(px(8'h77, 8'h27, 8'h36), 1);

        // Random traffic, backpressure and shadow updates
        for (int i = 0; i < 300; i++) begin
            cfg_we       = ($urandom_range(0, 3) == 0);
            cfg_ch       = 2'($urandom_range(0, 3));
            cfg_addr     = 8'($urandom_range(0, 255));
            cfg_wdata    = 8'($urandom_range(0, 255));
            cfg_swap_req = ($urandom_range(0, 19) == 0);
            drive_beat(PW'($urandom_range(0, (1 << PW) - 1)), ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 3) == 0), 1);
        end
        out_ready = 1'b1;
        repeat (4) tick();

        // Reset with beats in flight
        out_ready    = 1'b0;
        cfg_swap_req = 1'b1;
        drive_beat(px(8'd11, 8'd22, 8'd33), 1'b1, 1'b0, 0);
        drive_beat(px(8'd44, 8'd55, 8'd66), 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data", out_data, '0);
        check("mid_rst_out_sof", out_sof, 1'b0);
        check("mid_rst_active_bank", active_bank, 1'b0);
        check("mid_rst_swap_pending", swap_pending, 1'b0);
        tick();
        tick();
        out_ready = 1'b1;
        rst_n = 1'b1;
`ifdef GAMMA_IDENTITY_INIT_EN
        wait_init();
        drive_beat(px(8'd1, 8'd128, 8'd255), 1'b1, 1'b0, 0);
        lat2(px(8'd1, 8'd128, 8'd255), 1);
`else
        tick();
        drive_beat(px(8'd9, 8'd9, 8'd9), 1'b1, 1'b0, 0);
        lat2(px(8'd9, 8'd9, 8'd9), 0);
`endif

        begin
            int guard = 0;
            while (exp_q.size() != 0 && guard < 100) begin
                tick();
                guard++;
            end
            check("drain_empty", exp_q.size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
